miner_axis_ctrl: RTL and testbench

Sequencer between the AXI4-Stream input VIP/DMA path and the bitcoin miner core. Accepts a 20-word block header on a 32-bit AXI4-Stream slave and assembles the header fields. Pulses the miner start, waits for done or a timeout, then returns the 256-bit result as 8 words on a 32-bit AXI4-Stream master. Sits inside test_ip in place of the ad-hoc glue currently driving the miner.

---
 rtl/miner_ctrl_pkg.sv | 55 +++++
 rtl/miner_res_serializer.sv | 71 +++++++
 rtl/miner_axis_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_miner_axis_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/miner_ctrl_pkg.sv
// Shared types and constants for the miner AXI4-Stream sequencer.
//   state_e   : sequencer FSM states
//   hdr_t     : assembled block-header payload handed to the miner
//   put_word  : writes one 32-bit word into a 256-bit field, MS word at k=0
package miner_ctrl_pkg;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned HASH_W    = 256;
    localparam int unsigned IDX_W     = 5;
    localparam int unsigned RES_IDX_W = 3;
    localparam int unsigned TCNT_W    = 32;

    localparam int unsigned HDR_WORDS = 20;
    localparam int unsigned RES_WORDS = 8;

    // Header word-index boundaries; word 0 is the version.
    localparam int unsigned W_PREV    = 1;
    localparam int unsigned W_MERKLE  = 9;
    localparam int unsigned W_TIME    = 17;
    localparam int unsigned W_NBITS   = 18;
    localparam int unsigned W_NONCE   = 19;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_SEND  = 2'd3
    } state_e;

    typedef struct packed {
        logic [WORD_W-1:0] version;
        logic [HASH_W-1:0] prev_hash;
        logic [HASH_W-1:0] merkle;
        logic [WORD_W-1:0] blk_time;
        logic [WORD_W-1:0] nbits;
        logic [WORD_W-1:0] nonce;
    } hdr_t;

    // Word k lands in bits [255-32k -: 32].
    function automatic logic [HASH_W-1:0] put_word(
        input logic [HASH_W-1:0]    field,
        input logic [RES_IDX_W-1:0] k,
        input logic [WORD_W-1:0]    word
    );
        logic [HASH_W-1:0] r;
        r = field;
        for (int unsigned i = 0; i < RES_WORDS; i++) begin
            if (RES_IDX_W'(i) == k) begin
                r[HASH_W-1-WORD_W*i -: WORD_W] = word;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/miner_res_serializer.sv
// 256-bit to 8x32 AXI4-Stream serializer, MS word first.
//   aclk, aresetn : clock, async active-low reset
//   load_i        : capture data_i and start presenting word 0
//   data_i        : 256-bit result
//   tdata_o/tvalid_o/tlast_o/tready_i : AXI4-Stream master
//   last_hs_c_o   : combinational, high on the handshake of word 7
module miner_res_serializer
    import miner_ctrl_pkg::*;
(
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              load_i,
    input  logic [HASH_W-1:0] data_i,
    output logic [WORD_W-1:0] tdata_o,
    output logic              tvalid_o,
    output logic              tlast_o,
    input  logic              tready_i,
    output logic              last_hs_c_o
);

    logic [HASH_W-1:0]    buf_q, buf_d;
    logic [RES_IDX_W-1:0] idx_q, idx_d;
    logic                 tvalid_q, tvalid_d;
    logic                 tlast_q, tlast_d;
    logic                 hs_c;

    assign hs_c        = tvalid_q & tready_i;
    assign last_hs_c_o = hs_c && (idx_q == RES_IDX_W'(RES_WORDS - 1));

    // Shift the buffer left on each accepted word; the top word is always on tdata.
    always_comb begin
        buf_d    = buf_q;
        idx_d    = idx_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        if (load_i) begin
            buf_d    = data_i;
            idx_d    = '0;
            tvalid_d = 1'b1;
            tlast_d  = 1'b0;
        end else if (hs_c) begin
            if (idx_q == RES_IDX_W'(RES_WORDS - 1)) begin
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
            end else begin
                buf_d   = {buf_q[HASH_W-WORD_W-1:0], WORD_W'(0)};
                idx_d   = idx_q + RES_IDX_W'(1);
                tlast_d = (idx_d == RES_IDX_W'(RES_WORDS - 1));
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            buf_q    <= '0;
            idx_q    <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
        end else begin
            buf_q    <= buf_d;
            idx_q    <= idx_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
        end
    end

    assign tdata_o  = buf_q[HASH_W-1 -: WORD_W];
    assign tvalid_o = tvalid_q;
    assign tlast_o  = tlast_q;

endmodule

// File: rtl/miner_axis_ctrl.sv
// Sequencer between an AXI4-Stream header source and the bitcoin miner core.
//   s_axis_*   : 20-word block header in (slave)
//   m_axis_*   : 8-word 256-bit result out (master)
//   blk_*, prev_blk_header_hash, merkle_root_hash : header fields to miner
//   start / miner_abort : one-cycle pulses to miner
//   bitcoin_done/blk/nonce : miner result inputs
//   found_nonce, busy, hdr_err, timeout_err, blocks_done : status
module miner_axis_ctrl
    import miner_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter bit          CHECK_TLAST    = 1'b1
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [31:0]       s_axis_tdata,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready,
    output logic [31:0]       m_axis_tdata,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready,
    output logic [31:0]       blk_version,
    output logic [255:0]      prev_blk_header_hash,
    output logic [255:0]      merkle_root_hash,
    output logic [31:0]       blk_time,
    output logic [31:0]       blk_nbits,
    output logic [31:0]       blk_nonce,
    output logic              start,
    output logic              miner_abort,
    input  logic              bitcoin_done,
    input  logic [255:0]      bitcoin_blk,
    input  logic [31:0]       bitcoin_nonce,
    output logic [31:0]       found_nonce,
    output logic              busy,
    output logic              hdr_err,
    output logic              timeout_err,
    output logic [31:0]       blocks_done
);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    widx_q, widx_d;
    hdr_t                hdr_q, hdr_d;
    logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
    logic [WORD_W-1:0]   found_q, found_d;
    logic [WORD_W-1:0]   blocks_q, blocks_d;
    logic                hdr_err_q, hdr_err_d;
    logic                tout_err_q, tout_err_d;
    logic                start_q, start_d;
    logic                abort_q, abort_d;
    logic                tready_q, tready_d;
    logic                busy_q, busy_d;
    logic                s_hs_c;
    logic                ser_load_c;
    logic                ser_last_c;

    assign s_hs_c = s_axis_tvalid & tready_q;

    // Next-state, field assembly and status updates.
    always_comb begin
        state_d    = state_q;
        widx_d     = widx_q;
        hdr_d      = hdr_q;
        tcnt_d     = tcnt_q;
        found_d    = found_q;
        blocks_d   = blocks_q;
        hdr_err_d  = hdr_err_q;
        tout_err_d = tout_err_q;
        abort_d    = 1'b0;
        ser_load_c = 1'b0;

        unique case (state_q)
            ST_LOAD: begin
                if (s_hs_c) begin
                    // Early tlast: drop the word and restart the header.
                    if (CHECK_TLAST && s_axis_tlast && (widx_q != IDX_W'(W_NONCE))) begin
                        hdr_err_d = 1'b1;
                        widx_d    = '0;
                    end else begin
                        if (widx_q < IDX_W'(W_PREV)) begin
                            hdr_d.version = s_axis_tdata;
                        end else if (widx_q < IDX_W'(W_MERKLE)) begin
                            hdr_d.prev_hash = put_word(hdr_q.prev_hash,
                                RES_IDX_W'(widx_q - IDX_W'(W_PREV)), s_axis_tdata);
                        end else if (widx_q < IDX_W'(W_TIME)) begin
                            hdr_d.merkle = put_word(hdr_q.merkle,
                                RES_IDX_W'(widx_q - IDX_W'(W_MERKLE)), s_axis_tdata);
                        end else if (widx_q == IDX_W'(W_TIME)) begin
                            hdr_d.blk_time = s_axis_tdata;
                        end else if (widx_q == IDX_W'(W_NBITS)) begin
                            hdr_d.nbits = s_axis_tdata;
                        end else begin
                            hdr_d.nonce = s_axis_tdata;
                        end

                        if (widx_q == IDX_W'(HDR_WORDS - 1)) begin
                            // Missing tlast is flagged but the header is kept.
                            if (CHECK_TLAST && !s_axis_tlast) begin
                                hdr_err_d = 1'b1;
                            end
                            widx_d  = '0;
                            state_d = ST_START;
                        end else begin
                            widx_d = widx_q + IDX_W'(1);
                        end
                    end
                end
            end
            ST_START: begin
                tcnt_d  = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Done takes priority over a coincident timeout.
                if (bitcoin_done) begin
                    ser_load_c = 1'b1;
                    found_d    = bitcoin_nonce;
                    state_d    = ST_SEND;
                end else if ((TIMEOUT_CYCLES != 0) &&
                             (tcnt_q == TCNT_W'(TIMEOUT_CYCLES - 1))) begin
                    tout_err_d = 1'b1;
                    abort_d    = 1'b1;
                    state_d    = ST_LOAD;
                end else begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                end
            end
            ST_SEND: begin
                if (ser_last_c) begin
                    blocks_d = blocks_q + WORD_W'(1);
                    widx_d   = '0;
                    state_d  = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase

        // Registered decodes line up with the state they describe.
        start_d  = (state_d == ST_START);
        tready_d = (state_d == ST_LOAD);
        busy_d   = (state_d != ST_LOAD);
    end

    // State register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and status registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            widx_q     <= '0;
            hdr_q      <= '0;
            tcnt_q     <= '0;
            found_q    <= '0;
            blocks_q   <= '0;
            hdr_err_q  <= 1'b0;
            tout_err_q <= 1'b0;
            start_q    <= 1'b0;
            abort_q    <= 1'b0;
            tready_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            widx_q     <= widx_d;
            hdr_q      <= hdr_d;
            tcnt_q     <= tcnt_d;
            found_q    <= found_d;
            blocks_q   <= blocks_d;
            hdr_err_q  <= hdr_err_d;
            tout_err_q <= tout_err_d;
            start_q    <= start_d;
            abort_q    <= abort_d;
            tready_q   <= tready_d;
            busy_q     <= busy_d;
        end
    end

    miner_res_serializer u_ser (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .load_i      (ser_load_c),
        .data_i      (bitcoin_blk),
        .tdata_o     (m_axis_tdata),
        .tvalid_o    (m_axis_tvalid),
        .tlast_o     (m_axis_tlast),
        .tready_i    (m_axis_tready),
        .last_hs_c_o (ser_last_c)
    );

    assign s_axis_tready        = tready_q;
    assign blk_version          = hdr_q.version;
    assign prev_blk_header_hash = hdr_q.prev_hash;
    assign merkle_root_hash     = hdr_q.merkle;
    assign blk_time             = hdr_q.blk_time;
    assign blk_nbits            = hdr_q.nbits;
    assign blk_nonce            = hdr_q.nonce;
    assign start                = start_q;
    assign miner_abort          = abort_q;
    assign found_nonce          = found_q;
    assign busy                 = busy_q;
    assign hdr_err              = hdr_err_q;
    assign timeout_err          = tout_err_q;
    assign blocks_done          = blocks_q;

endmodule

// File: tb/tb_miner_axis_ctrl.sv
// Directed bench for miner_axis_ctrl with a simple miner model.
module tb_miner_axis_ctrl;

    logic         aclk = 1'b0;
    logic         aresetn;
    logic [31:0]  s_axis_tdata;
    logic         s_axis_tvalid;
    logic         s_axis_tlast;
    logic         s_axis_tready;
    logic [31:0]  m_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tlast;
    logic         m_axis_tready;
    logic [31:0]  blk_version;
    logic [255:0] prev_blk_header_hash;
    logic [255:0] merkle_root_hash;
    logic [31:0]  blk_time;
    logic [31:0]  blk_nbits;
    logic [31:0]  blk_nonce;
    logic         start;
    logic         miner_abort;
    logic         bitcoin_done;
    logic [255:0] bitcoin_blk;
    logic [31:0]  bitcoin_nonce;
    logic [31:0]  found_nonce;
    logic         busy;
    logic         hdr_err;
    logic         timeout_err;
    logic [31:0]  blocks_done;

    int vectors     = 0;
    int miscompares = 0;
    int bad_ready   = 0;

    logic         miner_en;
    logic [31:0]  m_cnt;
    logic         m_arm;
    logic [31:0]  hdr [20];
    logic [31:0]  exp_words [8];

    localparam logic [255:0] PREV   = 256'h671D0E2F_B2D7C1A4_5E3F2A91_0C8B7D6E_1F2E3D4C_5B6A7988_00000000_00000000;
    localparam logic [255:0] MERKLE = 256'h2CD900FC_1A2B3C4D_5E6F7081_92A3B4C5_D6E7F809_1A2B3C4D_5E6F7A8B_45F4992E;

    always #5 aclk = ~aclk;

    miner_axis_ctrl #(
        .TIMEOUT_CYCLES (100),
        .CHECK_TLAST    (1'b1)
    ) dut (
        .aclk                 (aclk),
        .aresetn              (aresetn),
        .s_axis_tdata         (s_axis_tdata),
        .s_axis_tvalid        (s_axis_tvalid),
        .s_axis_tlast         (s_axis_tlast),
        .s_axis_tready        (s_axis_tready),
        .m_axis_tdata         (m_axis_tdata),
        .m_axis_tvalid        (m_axis_tvalid),
        .m_axis_tlast         (m_axis_tlast),
        .m_axis_tready        (m_axis_tready),
        .blk_version          (blk_version),
        .prev_blk_header_hash (prev_blk_header_hash),
        .merkle_root_hash     (merkle_root_hash),
        .blk_time             (blk_time),
        .blk_nbits            (blk_nbits),
        .blk_nonce            (blk_nonce),
        .start                (start),
        .miner_abort          (miner_abort),
        .bitcoin_done         (bitcoin_done),
        .bitcoin_blk          (bitcoin_blk),
        .bitcoin_nonce        (bitcoin_nonce),
        .found_nonce          (found_nonce),
        .busy                 (busy),
        .hdr_err              (hdr_err),
        .timeout_err          (timeout_err),
        .blocks_done          (blocks_done)
    );

    // Miner model: done rises 50 cycles after start (if enabled) and holds until next start.
    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_cnt        <= '0;
            m_arm        <= 1'b0;
            bitcoin_done <= 1'b0;
        end else if (start) begin
            m_cnt        <= '0;
            m_arm        <= 1'b1;
            bitcoin_done <= 1'b0;
        end else if (m_arm) begin
            if (miner_en && m_cnt == 32'd49) begin
                bitcoin_done <= 1'b1;
                m_arm        <= 1'b0;
            end
            m_cnt <= m_cnt + 32'd1;
        end
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic build_header(input logic [31:0] ver, input logic [31:0] nc);
        hdr[0] = ver;
        for (int k = 0; k < 8; k++) begin
            hdr[1 + k] = PREV[255 - 32*k -: 32];
            hdr[9 + k] = MERKLE[255 - 32*k -: 32];
        end
        hdr[17] = 32'h74749054;
        hdr[18] = 32'h747B1B18;
        hdr[19] = nc;
    endtask

    task automatic set_exp(input logic [255:0] blk);
        bitcoin_blk = blk;
        for (int k = 0; k < 8; k++) exp_words[k] = blk[255 - 32*k -: 32];
    endtask

    // bad_last >= 0 puts tlast on that word and stops there.
    task automatic send_header(input int bad_last, input bit keep_valid);
        logic hs;
        int   n;
        for (int i = 0; i < 20; i++) begin
            s_axis_tdata  = hdr[i];
            s_axis_tvalid = 1'b1;
            s_axis_tlast  = (bad_last >= 0) ? (i == bad_last) : (i == 19);
            hs = 1'b0;
            n  = 0;
            while (!hs && n < 500) begin
                hs = s_axis_tready;
                if (s_axis_tready === busy) bad_ready++;
                tick();
                n++;
            end
            if (!hs) check($sformatf("hdr_hs_bound_w%0d", i), 256'(hs), 256'(1));
            if (i == bad_last) break;
        end
        if (!keep_valid) begin
            s_axis_tvalid = 1'b0;
            s_axis_tlast  = 1'b0;
        end
    endtask

    // Accept nwords result words; stall=1 gives a 2-low/6-high tready pattern.
    task automatic collect(input int nwords, input bit stall);
        int          got;
        int          cyc;
        logic [31:0] held;
        bit          was_stall;
        got = 0; cyc = 0; held = '0; was_stall = 1'b0;
        while (got < nwords && cyc < 2000) begin
            m_axis_tready = stall ? ((cyc % 8) >= 2) : 1'b1;
            if (s_axis_tready && busy) bad_ready++;
            if (was_stall) check("stall_hold", 256'({m_axis_tvalid, m_axis_tdata}), 256'({1'b1, held}));
            was_stall = 1'b0;
            if (m_axis_tvalid) begin
                if (m_axis_tready) begin
                    check($sformatf("word%0d", got), 256'(m_axis_tdata), 256'(exp_words[got]));
                    check($sformatf("tlast%0d", got), 256'(m_axis_tlast), 256'(got == 7));
                    got++;
                end else begin
                    held      = m_axis_tdata;
                    was_stall = 1'b1;
                end
            end
            tick();
            cyc++;
        end
        m_axis_tready = 1'b0;
        if (got < nwords) check("result_bound", 256'(got), 256'(nwords));
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        repeat (3) tick();
        aresetn = 1'b1;
        tick();
    endtask

    initial begin
        int  n;
        bit  seen;
        bit  saw_valid;

        aresetn       = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b0;
        miner_en      = 1'b1;
        bitcoin_nonce = '0;
        set_exp(256'h1);

        // Reset values.
        repeat (3) tick();
        check("rst_tready", 256'(s_axis_tready), 256'(0));
        check("rst_tvalid", 256'(m_axis_tvalid), 256'(0));
        check("rst_start", 256'(start), 256'(0));
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_blocks", 256'(blocks_done), 256'(0));
        check("rst_prev", prev_blk_header_hash, 256'(0));
        aresetn = 1'b1;
        tick();
        check("load_tready", 256'(s_axis_tready), 256'(1));

        // Test 1: reference header, done after 50 cycles, blk = 1.
        bitcoin_nonce = 32'h43F740C0;
        build_header(32'h02000000, 32'h43F740C0);
        send_header(-1, 1'b0);
        check("t1_start", 256'(start), 256'(1));
        check("t1_busy", 256'(busy), 256'(1));
        check("t1_tready", 256'(s_axis_tready), 256'(0));
        check("t1_version", 256'(blk_version), 256'(32'h02000000));
        check("t1_prev", prev_blk_header_hash, PREV);
        check("t1_merkle", merkle_root_hash, MERKLE);
        check("t1_time", 256'(blk_time), 256'(32'h74749054));
        check("t1_nbits", 256'(blk_nbits), 256'(32'h747B1B18));
        check("t1_nonce", 256'(blk_nonce), 256'(32'h43F740C0));
        tick();
        check("t1_start_width", 256'(start), 256'(0));
        collect(8, 1'b0);
        check("t1_found", 256'(found_nonce), 256'(32'h43F740C0));
        check("t1_blocks", 256'(blocks_done), 256'(1));
        check("t1_back_load", 256'(s_axis_tready), 256'(1));

        // Test 2: distinct result words under 2-low/6-high tready.
        set_exp(256'h11111111_22222222_33333333_44444444_55555555_66666666_77777777_88888888);
        bitcoin_nonce = 32'hDEADBEEF;
        build_header(32'h20000000, 32'h00000042);
        send_header(-1, 1'b0);
        check("t2_nonce_field", 256'(blk_nonce), 256'(32'h00000042));
        collect(8, 1'b1);
        check("t2_found", 256'(found_nonce), 256'(32'hDEADBEEF));
        check("t2_blocks", 256'(blocks_done), 256'(2));

        // Test 3: tlast on word 5, then a clean header.
        build_header(32'h0BADF00D, 32'h00000000);
        send_header(5, 1'b0);
        tick();
        check("t3_hdr_err", 256'(hdr_err), 256'(1));
        check("t3_still_load", 256'(busy), 256'(0));
        set_exp(256'hCAFEBABE_00000000_00000000_00000000_00000000_00000000_00000000_12345678);
        bitcoin_nonce = 32'h00C0FFEE;
        build_header(32'h03000000, 32'h0000ABCD);
        send_header(-1, 1'b0);
        check("t3_start", 256'(start), 256'(1));
        check("t3_version", 256'(blk_version), 256'(32'h03000000));
        check("t3_nonce_field", 256'(blk_nonce), 256'(32'h0000ABCD));
        collect(8, 1'b0);
        check("t3_blocks", 256'(blocks_done), 256'(3));
        check("t3_hdr_err_sticky", 256'(hdr_err), 256'(1));

        // Test 4: miner never done; abort is registered on the edge ending WAIT cycle 100.
        miner_en = 1'b0;
        m_axis_tready = 1'b1;
        build_header(32'h04000000, 32'h11110000);
        send_header(-1, 1'b0);
        check("t4_start", 256'(start), 256'(1));
        n = 0; seen = 1'b0; saw_valid = 1'b0;
        while (!seen && n < 300) begin
            tick();
            n++;
            if (m_axis_tvalid) saw_valid = 1'b1;
            if (miner_abort) seen = 1'b1;
        end
        check("t4_abort_cycle", 256'(n), 256'(101));
        check("t4_timeout_err", 256'(timeout_err), 256'(1));
        check("t4_no_tvalid", 256'(saw_valid), 256'(0));
        check("t4_back_load", 256'(s_axis_tready), 256'(1));
        tick();
        check("t4_abort_width", 256'(miner_abort), 256'(0));
        check("t4_blocks", 256'(blocks_done), 256'(3));
        m_axis_tready = 1'b0;

        // Test 5: reset during SEND word 3.
        miner_en = 1'b1;
        set_exp(256'hA0A0A0A0_B1B1B1B1_C2C2C2C2_D3D3D3D3_E4E4E4E4_F5F5F5F5_06060606_17171717);
        bitcoin_nonce = 32'h55AA55AA;
        build_header(32'h05000000, 32'h22220000);
        send_header(-1, 1'b0);
        collect(3, 1'b0);
        check("t5_word3_held", 256'({m_axis_tvalid, m_axis_tdata}), 256'({1'b1, 32'hD3D3D3D3}));
        aresetn = 1'b0;
        #1;
        check("t5_rst_tvalid", 256'(m_axis_tvalid), 256'(0));
        check("t5_rst_tdata", 256'(m_axis_tdata), 256'(0));
        check("t5_rst_busy", 256'(busy), 256'(0));
        check("t5_rst_blocks", 256'(blocks_done), 256'(0));
        check("t5_rst_hdr_err", 256'(hdr_err), 256'(0));
        check("t5_rst_timeout", 256'(timeout_err), 256'(0));
        check("t5_rst_found", 256'(found_nonce), 256'(0));
        check("t5_rst_version", 256'(blk_version), 256'(0));
        check("t5_rst_merkle", merkle_root_hash, 256'(0));
        tick();
        check("t5_rst_start", 256'(start), 256'(0));
        check("t5_rst_abort", 256'(miner_abort), 256'(0));
        aresetn = 1'b1;
        tick();
        send_header(-1, 1'b0);
        check("t5_version", 256'(blk_version), 256'(32'h05000000));
        collect(8, 1'b0);
        check("t5_found", 256'(found_nonce), 256'(32'h55AA55AA));
        check("t5_blocks", 256'(blocks_done), 256'(1));

        // Test 6: two back-to-back headers with tvalid held high throughout.
        do_reset();
        bad_ready = 0;
        set_exp(256'h00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000001);
        bitcoin_nonce = 32'h43F740C0;
        fork
            begin
                build_header(32'h06000000, 32'h33330000);
                send_header(-1, 1'b1);
                build_header(32'h07000000, 32'h44440000);
                send_header(-1, 1'b0);
            end
            begin
                collect(8, 1'b0);
                collect(8, 1'b0);
            end
        join
        check("t6_ready_outside_load", 256'(bad_ready), 256'(0));
        check("t6_version", 256'(blk_version), 256'(32'h07000000));
        check("t6_blocks", 256'(blocks_done), 256'(2));
        check("t6_hdr_err", 256'(hdr_err), 256'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
